// File: rtl/kisc_control_unit.sv
// ---------------------------------------------------------------------------
// kisc_control_unit
//
// Multi-cycle control FSM for the KISC-V RV32I core. It also sequences the APB
// master: instruction fetch and load/store go over APB, and it decodes the
// instruction group code (op_jmp). It holds no data; it only drives enables to
// the regfile, the ALU operand muxes, the datapath muxes and the program counter.
//
// Optional feature macro: CU_PERR_HALT_EN
//   defined   : a completed APB transfer flagged with APB_perr parks the unit in
//               an error state with every output low until reset.
//   undefined : APB_perr is ignored.
//
// Ports
//   APB_PCLK, APB_PRESETn     clock, synchronous active-low reset
//   APB_psel/penable/pwrite   APB master control
//   APB_pready, APB_perr      APB slave response
//   interrupt, system_mem     level interrupt request, PC in system region
//   op_jmp, cmp_flag, immediate  decoded group, branch compare result, I-type
//   load_pdata .. alu_imm_i   datapath / regfile / PC enables
// ---------------------------------------------------------------------------
module kisc_control_unit (
  input  logic       APB_PCLK,
  input  logic       APB_PRESETn,
  output logic       APB_psel,
  output logic       APB_penable,
  output logic       APB_pwrite,
  input  logic       APB_pready,
  input  logic       APB_perr,
  input  logic       interrupt,
  input  logic       system_mem,
  input  logic [3:0] op_jmp,
  input  logic       cmp_flag,
  input  logic       immediate,
  output logic       load_pdata,
  output logic       load_pc,
  output logic       load_insr,
  output logic       write_reg,
  output logic       read_reg,
  output logic       mem_access,
  output logic       increment,
  output logic       sys_load,
  output logic       lui_flag,
  output logic       jal_flag,
  output logic       sys_load_pc,
  output logic       alu_flag,
  output logic       load_branch,
  output logic       load_jalr,
  output logic       pwrite,
  output logic       alu_rs1,
  output logic       alu_imm_i
);

  localparam logic [3:0] OpStore  = 4'd1;
  localparam logic [3:0] OpLoad   = 4'd2;
  localparam logic [3:0] OpSystem = 4'd3;
  localparam logic [3:0] OpAlu    = 4'd4;
  localparam logic [3:0] OpJalr   = 4'd5;
  localparam logic [3:0] OpBranch = 4'd6;
  localparam logic [3:0] OpLui    = 4'd7;
  localparam logic [3:0] OpJal    = 4'd15;

  typedef enum logic [3:0] {
    StBound,
    StTrap,
    StFSet,
    StFAcc,
    StDec,
    StExe,
    StMSet,
    StMAcc,
    StErr
  } state_e;

  state_e state_q, state_d;
  // Store/load choice captured in EXE so the bus direction stays fixed across
  // setup and access even if op_jmp moves during the memory phase.
  logic   store_q, store_d;
  logic   perr_hit;

`ifdef CU_PERR_HALT_EN
  assign perr_hit = APB_pready & APB_perr;
`else
  logic unused_perr;
  assign perr_hit    = 1'b0;
  assign unused_perr = APB_perr;
`endif

  always_ff @(posedge APB_PCLK) begin
    if (!APB_PRESETn) begin
      state_q <= StBound;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    APB_psel    = 1'b0;
    APB_penable = 1'b0;
    APB_pwrite  = 1'b0;
    load_pdata  = 1'b0;
    load_pc     = 1'b0;
    load_insr   = 1'b0;
    write_reg   = 1'b0;
    read_reg    = 1'b0;
    mem_access  = 1'b0;
    increment   = 1'b0;
    sys_load    = 1'b0;
    lui_flag    = 1'b0;
    jal_flag    = 1'b0;
    sys_load_pc = 1'b0;
    alu_flag    = 1'b0;
    load_branch = 1'b0;
    load_jalr   = 1'b0;
    pwrite      = 1'b0;
    alu_rs1     = 1'b0;
    alu_imm_i   = 1'b0;

    case (state_q)
      StBound: begin
        // Interrupts are only taken outside the system region.
        state_d = (interrupt && !system_mem) ? StTrap : StFSet;
      end

      StTrap: begin
        load_pc     = 1'b1;
        sys_load_pc = 1'b1;
        state_d     = StFSet;
      end

      StFSet: begin
        APB_psel = 1'b1;
        state_d  = StFAcc;
      end

      StFAcc: begin
        APB_psel    = 1'b1;
        APB_penable = 1'b1;
        if (APB_pready) begin
          if (perr_hit) begin
            state_d = StErr;
          end else begin
            load_insr = 1'b1;
            increment = 1'b1;
            state_d   = StDec;
          end
        end
      end

      StDec: begin
        read_reg = 1'b1;
        state_d  = StExe;
      end

      StExe: begin
        state_d = StBound;
        store_d = (op_jmp == OpStore);
        case (op_jmp)
          OpStore, OpLoad: state_d = StMSet;
          OpAlu: begin
            write_reg = 1'b1;
            alu_flag  = 1'b1;
            alu_imm_i = immediate;
            alu_rs1   = !immediate;
          end
          OpLui: begin
            write_reg = 1'b1;
            lui_flag  = 1'b1;
          end
          OpJal: begin
            write_reg = 1'b1;
            jal_flag  = 1'b1;
            load_pc   = 1'b1;
          end
          OpJalr: begin
            write_reg = 1'b1;
            jal_flag  = 1'b1;
            load_jalr = 1'b1;
            load_pc   = 1'b1;
          end
          OpBranch: begin
            alu_rs1 = 1'b1;
            if (cmp_flag) begin
              load_branch = 1'b1;
              load_pc     = 1'b1;
            end
          end
          OpSystem: begin
            if (!system_mem) begin
              load_pc     = 1'b1;
              sys_load_pc = 1'b1;
            end
          end
          default: ;
        endcase
      end

      StMSet: begin
        APB_psel   = 1'b1;
        mem_access = 1'b1;
        APB_pwrite = store_q;
        pwrite     = store_q;
        load_pdata = store_q;
        state_d    = StMAcc;
      end

      StMAcc: begin
        APB_psel    = 1'b1;
        APB_penable = 1'b1;
        mem_access  = 1'b1;
        APB_pwrite  = store_q;
        pwrite      = store_q;
        load_pdata  = store_q;
        if (APB_pready) begin
          if (perr_hit) begin
            state_d = StErr;
          end else begin
            write_reg = !store_q;
            sys_load  = !store_q;
            state_d   = StBound;
          end
        end
      end

      // Terminal: only reset leaves this state.
      StErr: state_d = StErr;

      default: state_d = StBound;
    endcase
  end

endmodule

// File: tb/tb_kisc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_kisc_control_unit
//
// Self-checking bench for kisc_control_unit. Each instruction is described as
// a transaction (group, wait states, interrupt, compare/immediate flags); the
// expected output vector for every cycle of that instruction is derived from
// the group rules and compared against the DUT at the falling edge.
// ---------------------------------------------------------------------------
module tb_kisc_control_unit;

  logic       APB_PCLK;
  logic       APB_PRESETn;
  logic       APB_psel, APB_penable, APB_pwrite;
  logic       APB_pready, APB_perr;
  logic       interrupt, system_mem;
  logic [3:0] op_jmp;
  logic       cmp_flag, immediate;
  logic       load_pdata, load_pc, load_insr, write_reg, read_reg, mem_access;
  logic       increment, sys_load, lui_flag, jal_flag, sys_load_pc, alu_flag;
  logic       load_branch, load_jalr, pwrite, alu_rs1, alu_imm_i;

  kisc_control_unit dut (
    .APB_PCLK    (APB_PCLK),
    .APB_PRESETn (APB_PRESETn),
    .APB_psel    (APB_psel),
    .APB_penable (APB_penable),
    .APB_pwrite  (APB_pwrite),
    .APB_pready  (APB_pready),
    .APB_perr    (APB_perr),
    .interrupt   (interrupt),
    .system_mem  (system_mem),
    .op_jmp      (op_jmp),
    .cmp_flag    (cmp_flag),
    .immediate   (immediate),
    .load_pdata  (load_pdata),
    .load_pc     (load_pc),
    .load_insr   (load_insr),
    .write_reg   (write_reg),
    .read_reg    (read_reg),
    .mem_access  (mem_access),
    .increment   (increment),
    .sys_load    (sys_load),
    .lui_flag    (lui_flag),
    .jal_flag    (jal_flag),
    .sys_load_pc (sys_load_pc),
    .alu_flag    (alu_flag),
    .load_branch (load_branch),
    .load_jalr   (load_jalr),
    .pwrite      (pwrite),
    .alu_rs1     (alu_rs1),
    .alu_imm_i   (alu_imm_i)
  );

  initial APB_PCLK = 1'b0;
  always #5 APB_PCLK = ~APB_PCLK;

  // Output vector bit masks (order matches the packing in the compare process).
  localparam logic [19:0] M_PSEL  = 20'h80000;
  localparam logic [19:0] M_PEN   = 20'h40000;
  localparam logic [19:0] M_APWR  = 20'h20000;
  localparam logic [19:0] M_PDATA = 20'h10000;
  localparam logic [19:0] M_LDPC  = 20'h08000;
  localparam logic [19:0] M_INSR  = 20'h04000;
  localparam logic [19:0] M_WR    = 20'h02000;
  localparam logic [19:0] M_RD    = 20'h01000;
  localparam logic [19:0] M_MEM   = 20'h00800;
  localparam logic [19:0] M_INC   = 20'h00400;
  localparam logic [19:0] M_SYS   = 20'h00200;
  localparam logic [19:0] M_LUI   = 20'h00100;
  localparam logic [19:0] M_JAL   = 20'h00080;
  localparam logic [19:0] M_SYSPC = 20'h00040;
  localparam logic [19:0] M_ALU   = 20'h00020;
  localparam logic [19:0] M_BR    = 20'h00010;
  localparam logic [19:0] M_JALR  = 20'h00008;
  localparam logic [19:0] M_PWR   = 20'h00004;
  localparam logic [19:0] M_RS1   = 20'h00002;
  localparam logic [19:0] M_IMM   = 20'h00001;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          wr_cnt   = 0;
  int          cyc      = 0;
  bit          chk_en   = 1'b0;
  logic [19:0] exp_q    = '0;
  logic [19:0] act;

  // Single compare process: full output vector plus the two exclusivity rules.
  always @(negedge APB_PCLK) begin
    if (chk_en) begin
      act = {APB_psel, APB_penable, APB_pwrite, load_pdata, load_pc, load_insr,
             write_reg, read_reg, mem_access, increment, sys_load, lui_flag,
             jal_flag, sys_load_pc, alu_flag, load_branch, load_jalr, pwrite,
             alu_rs1, alu_imm_i};
      n_checks++;
      if (act === exp_q) n_pass++;
      else $display("FAIL outputs cycle %0d: got %05h expected %05h", cyc, act, exp_q);
      n_checks++;
      if (!(write_reg && load_pdata) && !(increment && load_pc)) n_pass++;
      else $display("FAIL exclusivity cycle %0d: got %05h expected no wr&pdata, inc&ldpc",
                    cyc, act);
      if (write_reg === 1'b1) wr_cnt++;
    end
  end

  task automatic step(input logic [19:0] e);
    exp_q = e;
    @(posedge APB_PCLK);
    #1;
    cyc++;
  endtask

  task automatic rand_in();
    APB_pready = 1'($urandom);
    APB_perr   = 1'($urandom);
    interrupt  = 1'($urandom);
    system_mem = 1'($urandom);
    op_jmp     = 4'($urandom);
    cmp_flag   = 1'($urandom);
    immediate  = 1'($urandom);
  endtask

  // Expected EXE-cycle outputs for each instruction group.
  function automatic logic [19:0] exe_vec(input logic [3:0] op, input logic cmp,
                                          input logic imm, input logic smem);
    case (op)
      4'd4:    return M_WR | M_ALU | (imm ? M_IMM : M_RS1);
      4'd7:    return M_WR | M_LUI;
      4'd15:   return M_WR | M_JAL | M_LDPC;
      4'd5:    return M_WR | M_JAL | M_JALR | M_LDPC;
      4'd6:    return M_RS1 | (cmp ? (M_BR | M_LDPC) : 20'h0);
      4'd3:    return smem ? 20'h0 : (M_LDPC | M_SYSPC);
      default: return 20'h0;
    endcase
  endfunction

  // One full instruction from the BOUND cycle to the return to BOUND.
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw,
                           input logic intr, input logic smem, input logic cmp,
                           input logic imm, input logic smem_x);
    logic [19:0] sb;
    bit          is_st, is_ld;
    is_st = (op == 4'd1);
    is_ld = (op == 4'd2);
    sb    = is_st ? (M_APWR | M_PWR | M_PDATA) : 20'h0;
    rand_in(); interrupt = intr; system_mem = smem;
    step(20'h0);
    if (intr && !smem) begin
      rand_in();
      step(M_LDPC | M_SYSPC);
    end
    rand_in();
    step(M_PSEL);
    for (int i = 0; i < fw; i++) begin
      rand_in(); APB_pready = 1'b0;
      step(M_PSEL | M_PEN);
    end
    rand_in(); APB_pready = 1'b1;
    step(M_PSEL | M_PEN | M_INSR | M_INC);
    rand_in(); op_jmp = op;
    step(M_RD);
    rand_in(); op_jmp = op; cmp_flag = cmp; immediate = imm; system_mem = smem_x;
    step(exe_vec(op, cmp, imm, smem_x));
    if (is_st || is_ld) begin
      rand_in(); op_jmp = op;
      step(M_PSEL | M_MEM | sb);
      for (int i = 0; i < mw; i++) begin
        rand_in(); op_jmp = op; APB_pready = 1'b0;
        step(M_PSEL | M_PEN | M_MEM | sb);
      end
      rand_in(); op_jmp = op; APB_pready = 1'b1;
      step(M_PSEL | M_PEN | M_MEM | sb | (is_ld ? (M_WR | M_SYS) : 20'h0));
    end
  endtask

  logic [3:0] ops [10];
  int         wr_before;

  initial begin
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd15, 4'd0, 4'd9};
    APB_PRESETn = 1'b0;
    rand_in();
    @(posedge APB_PCLK);
    #1;
    chk_en = 1'b1;
    // Reset held: all outputs low regardless of inputs.
    rand_in(); step(20'h0);
    rand_in(); step(20'h0);
    APB_PRESETn = 1'b1;

    // Directed ALU I-type, zero wait, literal vectors.
    rand_in(); interrupt = 1'b0;
    step(20'h00000);
    rand_in(); step(20'h80000);
    rand_in(); APB_pready = 1'b1; step(20'hC4400);
    rand_in(); op_jmp = 4'd4; step(20'h01000);
    rand_in(); op_jmp = 4'd4; immediate = 1'b1; step(20'h02021);

    // Directed LOAD, 3 wait states in M_ACC, literal vectors.
    wr_before = wr_cnt;
    rand_in(); interrupt = 1'b0;
    step(20'h00000);
    rand_in(); step(20'h80000);
    rand_in(); APB_pready = 1'b1; step(20'hC4400);
    rand_in(); op_jmp = 4'd2; step(20'h01000);
    rand_in(); op_jmp = 4'd2; step(20'h00000);
    rand_in(); op_jmp = 4'd2; step(20'h80800);
    for (int i = 0; i < 3; i++) begin
      rand_in(); op_jmp = 4'd2; APB_pready = 1'b0; step(20'hC0800);
    end
    rand_in(); op_jmp = 4'd2; APB_pready = 1'b1; step(20'hC2A00);
    n_checks++;
    if (wr_cnt - wr_before == 1) n_pass++;
    else $display("FAIL load_wr_once: got %0d pulses expected 1", wr_cnt - wr_before);

    // Directed STORE with one wait state, literal vectors.
    rand_in(); interrupt = 1'b0;
    step(20'h00000);
    rand_in(); step(20'h80000);
    rand_in(); APB_pready = 1'b1; step(20'hC4400);
    rand_in(); op_jmp = 4'd1; step(20'h01000);
    rand_in(); op_jmp = 4'd1; step(20'h00000);
    rand_in(); op_jmp = 4'd1; step(20'hB0804);
    rand_in(); op_jmp = 4'd1; APB_pready = 1'b0; step(20'hF0804);
    rand_in(); op_jmp = 4'd1; APB_pready = 1'b1; step(20'hF0804);

    // Directed trap entry then a normal fetch.
    rand_in(); interrupt = 1'b1; system_mem = 1'b0;
    step(20'h00000);
    rand_in(); step(20'h08040);
    rand_in(); step(20'h80000);
    rand_in(); APB_pready = 1'b1; step(20'hC4400);
    rand_in(); op_jmp = 4'd6; step(20'h01000);
    rand_in(); op_jmp = 4'd6; cmp_flag = 1'b1; step(20'h08012);

    // Branch not taken, interrupt masked by system region.
    run_instr(4'd6, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-fetch aborts to BOUND on the next edge.
    rand_in(); interrupt = 1'b0;
    step(20'h0);
    rand_in(); step(M_PSEL);
    rand_in(); APB_pready = 1'b0; APB_PRESETn = 1'b0; step(M_PSEL | M_PEN);
    rand_in(); step(20'h0);
    APB_PRESETn = 1'b1;

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      run_instr(ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
